// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter and one-cycle strobe sequencer.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default: port 0 priority).
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              input_clk,
  input  logic              input_rst,
  input  logic              input_req0,
  input  logic              input_req1,
  input  logic              input_we0,
  input  logic              input_we1,
  input  logic [ADDR_W-1:0] input_addr0,
  input  logic [ADDR_W-1:0] input_addr1,
  input  logic [DATA_W-1:0] input_wdata0,
  input  logic [DATA_W-1:0] input_wdata1,
  output logic              output_ack0,
  output logic              output_ack1,
  output logic [DATA_W-1:0] output_rdata0,
  output logic [DATA_W-1:0] output_rdata1,
  output logic              output_mem_write_flag,
  output logic              output_mem_read_flag,
  output logic [ADDR_W-1:0] output_mem_addr,
  output logic [DATA_W-1:0] output_mem_data,
  input  logic [DATA_W-1:0] input_mem_rdata,
  output logic              output_busy,
  output logic              output_grant
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    RELEASE,
    ACK
  } state_t;

  state_t state, state_nx;
  logic   we_q;
  logic   any_req;
  logic   winner;
  logic   take;

  assign any_req = input_req0 | input_req1;
  assign take    = (state == IDLE) & any_req;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;

  // rr_ptr is the last-served port; the other one wins a tie
  always_comb begin
    if (input_req0 && input_req1)
      winner = ~rr_ptr;
    else
      winner = input_req1;
  end

  always_ff @(posedge input_clk or posedge input_rst) begin
    if (input_rst)
      rr_ptr <= 1'b1;
    else if (take)
      rr_ptr <= winner;
  end
`else
  assign winner = ~input_req0 & input_req1;
`endif

  always_ff @(posedge input_clk or posedge input_rst) begin
    if (input_rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = STROBE;
      STROBE:  state_nx = RELEASE;
      RELEASE: state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    output_mem_write_flag = (state == STROBE) & we_q;
    output_mem_read_flag  = (state == STROBE) & ~we_q;
    output_ack0           = (state == ACK) & ~output_grant;
    output_ack1           = (state == ACK) & output_grant;
    output_busy           = (state != IDLE);
  end

  // Mem-side request is frozen from grant until the next grant
  always_ff @(posedge input_clk or posedge input_rst) begin
    if (input_rst) begin
      we_q            <= 1'b0;
      output_grant    <= 1'b0;
      output_mem_addr <= '0;
      output_mem_data <= '0;
    end else if (take) begin
      output_grant    <= winner;
      we_q            <= winner ? input_we1 : input_we0;
      output_mem_addr <= winner ? input_addr1 : input_addr0;
      output_mem_data <= winner ? input_wdata1 : input_wdata0;
    end
  end

  always_ff @(posedge input_clk or posedge input_rst) begin
    if (input_rst) begin
      output_rdata0 <= '0;
      output_rdata1 <= '0;
    end else if (state == RELEASE && !we_q) begin
      if (output_grant)
        output_rdata1 <= input_mem_rdata;
      else
        output_rdata0 <= input_mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with an edge-triggered memory model.
// Expected arbitration order follows DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        wf, rf;
  logic [7:0]  maddr;
  logic [31:0] mdata;
  logic [31:0] mem_rdata = '0;
  logic        busy, grant;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  logic       p_wf = 1'b0, p_rf = 1'b0, p_busy = 1'b0;
  logic [7:0] p_addr = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .input_clk(clk),
    .input_rst(rst),
    .input_req0(req0),
    .input_req1(req1),
    .input_we0(we0),
    .input_we1(we1),
    .input_addr0(addr0),
    .input_addr1(addr1),
    .input_wdata0(wdata0),
    .input_wdata1(wdata1),
    .output_ack0(ack0),
    .output_ack1(ack1),
    .output_rdata0(rdata0),
    .output_rdata1(rdata1),
    .output_mem_write_flag(wf),
    .output_mem_read_flag(rf),
    .output_mem_addr(maddr),
    .output_mem_data(mdata),
    .input_mem_rdata(mem_rdata),
    .output_busy(busy),
    .output_grant(grant)
  );

  always @(posedge wf) mem[maddr] = mdata;
  always @(posedge rf) mem_rdata = mem[maddr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and run the always-on protocol checks
  task automatic tick();
    @(posedge clk);
    #1;
    chk("flags_exclusive", {31'd0, wf & rf}, 32'd0);
    chk("flag_one_cycle", {31'd0, (wf & p_wf) | (rf & p_rf)}, 32'd0);
    if (busy && p_busy)
      chk("addr_stable", {24'd0, maddr}, {24'd0, p_addr});
    p_wf   = wf;
    p_rf   = rf;
    p_busy = busy;
    p_addr = maddr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_p;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'hFF] = 32'h12345678;
    mem[8'h01] = 32'h11111111;
    mem[8'h02] = 32'h22222222;

    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_flags", {30'd0, wf, rf}, 32'd0);
    chk("rst_acks", {30'd0, ack0, ack1}, 32'd0);
    chk("rst_addr", {24'd0, maddr}, 32'd0);
    chk("rst_data", mdata, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);

    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 32'hDEADBEEF;
    tick();
    chk("w0_wflag", {31'd0, wf}, 32'd1);
    chk("w0_rflag", {31'd0, rf}, 32'd0);
    chk("w0_busy", {31'd0, busy}, 32'd1);
    chk("w0_addr", {24'd0, maddr}, 32'h10);
    chk("w0_data", mdata, 32'hDEADBEEF);
    chk("w0_grant", {31'd0, grant}, 32'd0);
    tick();
    chk("w0_release_wflag", {31'd0, wf}, 32'd0);
    chk("w0_release_ack", {31'd0, ack0}, 32'd0);
    tick();
    chk("w0_ack0", {31'd0, ack0}, 32'd1);
    chk("w0_ack1", {31'd0, ack1}, 32'd0);
    chk("w0_rdata0_kept", rdata0, 32'd0);
    req0 = 1'b0;
    tick();
    chk("w0_idle_ack", {31'd0, ack0}, 32'd0);
    chk("w0_idle_busy", {31'd0, busy}, 32'd0);
    chk("w0_mem", mem[8'h10], 32'hDEADBEEF);

    req0 = 1'b1; we0 = 1'b0;
    tick();
    chk("r0_rflag", {31'd0, rf}, 32'd1);
    chk("r0_wflag", {31'd0, wf}, 32'd0);
    tick();
    chk("r0_release_rflag", {31'd0, rf}, 32'd0);
    tick();
    chk("r0_ack0", {31'd0, ack0}, 32'd1);
    chk("r0_ack1", {31'd0, ack1}, 32'd0);
    chk("r0_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 1'b0;
    tick();

    req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
    tick();
    chk("r1_grant", {31'd0, grant}, 32'd1);
    chk("r1_rflag", {31'd0, rf}, 32'd1);
    chk("r1_addr", {24'd0, maddr}, 32'hFF);
    tick();
    tick();
    chk("r1_ack1", {31'd0, ack1}, 32'd1);
    chk("r1_ack0", {31'd0, ack0}, 32'd0);
    chk("r1_rdata1", rdata1, 32'h12345678);
    chk("r1_rdata0_kept", rdata0, 32'hDEADBEEF);
    req1 = 1'b0;
    tick();

    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    for (int r = 0; r < 4; r++) begin
`ifdef DMEM_ARB_RR_EN
      exp_p = r[0];
`else
      exp_p = 1'b0;
`endif
      tick();
      chk("arb_grant", {31'd0, grant}, {31'd0, exp_p});
      tick();
      tick();
      chk("arb_ack0", {31'd0, ack0}, {31'd0, ~exp_p});
      chk("arb_ack1", {31'd0, ack1}, {31'd0, exp_p});
      if (exp_p)
        chk("arb_rdata1", rdata1, 32'h22222222);
      else
        chk("arb_rdata0", rdata0, 32'h11111111);
      tick();
      chk("arb_idle", {31'd0, busy}, 32'd0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk("arb_done_busy", {31'd0, busy}, 32'd0);

    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 32'hA5A5A5A5;
    tick();
    chk("rw_wflag", {31'd0, wf}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rw_wflag_drop", {31'd0, wf}, 32'd0);
    chk("rw_busy_drop", {31'd0, busy}, 32'd0);
    chk("rw_ack_none", {30'd0, ack0, ack1}, 32'd0);
    chk("rw_addr_clr", {24'd0, maddr}, 32'd0);
    chk("rw_rdata0_clr", rdata0, 32'd0);
    chk("rw_rdata1_clr", rdata1, 32'd0);
    req0 = 1'b0;
    tick();
    chk("rw_ack_hold", {30'd0, ack0, ack1}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rw_post_busy", {31'd0, busy}, 32'd0);
    chk("rw_post_ack", {30'd0, ack0, ack1}, 32'd0);

    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    tick();
    chk("rr_rflag", {31'd0, rf}, 32'd1);
    tick();
    tick();
    chk("rr_ack1", {31'd0, ack1}, 32'd1);
    chk("rr_rdata1", rdata1, 32'hA5A5A5A5);
    req1 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
